hyperram_line_cache: RTL
========================

# hyperram_line_cache

Parametrised, direct-mapped, write-back line cache between the Avalon-MM `s0` slave port and the HyperRAM burst engines (read-burst and write-burst state machines). It replaces the fixed single 8-word buffer with `LINES` lines of `WORDS` words, tracks a dirty bit per line, and writes back only dirty victims. It adds an explicit flush so software can force dirty data to HyperRAM. Hits complete without any HyperRAM traffic; misses stall `s0` via `s0_waitrequest` while the cache runs an evict burst and/or a fill burst on the memory-side command interface.

## Interface
Parameters:
- `ADDR_W`, 22: word address width of `s0_address` and `mem_cmd_addr`.
- `DATA_W`, 32: word width.
- `WORDS`, 8: words per line; must be a power of 2 and ≥2. `OFS_W = log2(WORDS)`.
- `LINES`, 4: number of lines; must be a power of 2 and ≥2. `IDX_W = log2(LINES)`. Tag = `ADDR_W-OFS_W-IDX_W` bits.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `s0_address`  in  ADDR_W  word address: offset `[OFS_W-1:0]`, index next `IDX_W` bits, tag above.
- `s0_read` / `s0_write`  in  1  Avalon request; never both high together.
- `s0_writedata`  in  DATA_W  write data.
- `s0_readdata`  out  DATA_W  read data, registered.
- `s0_readdatavalid`  out  1  one-cycle pulse per accepted read.
- `s0_waitrequest`  out  1  combinational stall.
- `mem_cmd_valid`  out  1  burst command request.
- `mem_cmd_ready`  in  1  command accepted when both valid and ready are high.
- `mem_cmd_write`  out  1  1 = write burst (evict), 0 = read burst (fill).
- `mem_cmd_addr`  out  ADDR_W  line base address, offset bits 0.
- `mem_wdata`  out  DATA_W  evict word at the current beat counter.
- `mem_wdata_valid`  out  1  high in EVICT_DATA.
- `mem_wdata_ready`  in  1  beat consumed when valid and ready are high.
- `mem_rdata`  in  DATA_W  fill word.
- `mem_rdata_valid`  in  1  fill beat strobe.
- `mem_done`  in  1  burst complete pulse.
- `flush`  in  1  flush request pulse.
- `flush_busy`  out  1  flush in progress.
- `err`  out  1  sticky short-fill error.

## Operation
States and transitions:
- IDLE
  - If `flush` is high, go to FLUSH_SCAN. Flush has priority over an `s0` request in the same cycle.
  - On a request, a hit means `valid[idx]` is set and `tag[idx]` matches. A hit is accepted in the same cycle.
    - Read hit: `s0_readdata <= line[idx][ofs]`.
    - Write hit: the word is written and `dirty[idx] <= 1`.
  - On a miss, the request is not accepted. Go to EVICT_CMD if the victim is valid and dirty; otherwise go to FILL_CMD.
- EVICT_CMD
  - Drive `mem_cmd_write=1` and `mem_cmd_addr={victim_tag, idx, 0}`.
  - On cmd handshake, go to EVICT_DATA with beat counter 0.
- EVICT_DATA
  - Each beat handshake increments the counter.
  - After beat `WORDS-1`, go to EVICT_WAIT.
- EVICT_WAIT
  - On `mem_done`, clear `dirty[idx]`.
  - Go to FILL_CMD, or back to FLUSH_SCAN when flushing.
- FILL_CMD
  - Drive `mem_cmd_write=0` and `mem_cmd_addr={req_tag, idx, 0}`.
  - On handshake, go to FILL_DATA with counter 0.
- FILL_DATA
  - Each `mem_rdata_valid` writes `line[idx][cnt]` and increments `cnt`.
  - On `mem_done` with a complete fill (`cnt==WORDS`, including a beat in the same cycle): set `valid`, set `tag`, clear `dirty`, go to IDLE.
  - On `mem_done` with a short fill: set `err`, leave the line invalid, go to IDLE.
  - Extra beats after `cnt==WORDS` are ignored.
- FLUSH_SCAN
  - Walk indices 0..LINES-1, one cycle per clean or invalid line.
  - For a dirty line, run EVICT_CMD/EVICT_DATA/EVICT_WAIT, then resume at the next index.
  - After the last index, go to IDLE.
  - Lines stay valid after the flush; dirty bits are cleared.
- The pending `s0` request is held by the master and re-evaluated in IDLE, so it hits after the fill.

Stall rule:
- `s0_waitrequest = (state != IDLE) | flush | ((s0_read | s0_write) & !hit)`.

## Timing
- Reset values:
  - State IDLE; all `valid`, `dirty` and `err` cleared; counters 0.
  - `s0_readdata=0`, `s0_readdatavalid=0`.
  - `mem_cmd_valid=0`, `mem_cmd_write=0`, `mem_cmd_addr=0`, `mem_wdata_valid=0`.
  - `flush_busy=0`; line data is not reset.
- Reset asserted mid-burst aborts the burst at the next edge and all lines become invalid. The burst engines share `rst`.
- Read hit: `s0_readdatavalid` pulses exactly 1 cycle after the accept edge.
- Write hit: zero wait states.
- `mem_cmd_valid` stays high until the handshake; `mem_cmd_addr` is stable while valid.
- Miss penalty ≥ 2 + WORDS cycles for fill only, ≥ 4 + 2·WORDS cycles with an evict, plus engine latency.
- `flush_busy` is high from the cycle after `flush` is sampled until the cycle FLUSH_SCAN exits.

## Configuration
- `HYPERRAM_CACHE_FLUSH_EN`
  - Defined: flush behaves as above.
  - Undefined: the `flush` input is ignored, FLUSH_SCAN is not built, and `flush_busy` is tied to 0. Dirty data reaches HyperRAM only on eviction.

## Test plan
All scenarios use `LINES=4`, `WORDS=8`.

- Reset, then read `0x000010` (idx 2, tag 0) → read cmd at addr `0x000010`; supply `0xA0..0xA7` plus `mem_done` → `s0_readdata=0xA0` with `readdatavalid` 1 cycle after accept; no write cmd.
- Write `0x000011`=`0xDEADBEEF` → `waitrequest` 0, no mem cmd; read `0x000011` → `0xDEADBEEF`.
- Read `0x000030` (idx 2, tag 1) → write burst at `0x000010` carrying `A0, DEADBEEF, A2..A7`, then read burst at `0x000030`; first data returned is from the new fill.
- Dirty lines at idx 0 and 3, pulse `flush` → write bursts at idx 0 then idx 3 only; `flush_busy` falls after the second `mem_done`. The following read of those addresses hits.
- Fill with `mem_done` after 5 beats → `err=1`, line invalid, held request issues a new read cmd; `err` stays 1 until `rst`.
- `rst` during EVICT_DATA beat 3 → next cycle `mem_cmd_valid=0`, `mem_wdata_valid=0`; a repeat read misses.

Source files
------------

// File: rtl/hyperram_line_cache.sv
// Direct-mapped write-back line cache between the Avalon s0 slave and the HyperRAM burst engines.
// Flush support (FLUSH_SCAN, flush_busy) is built only when HYPERRAM_CACHE_FLUSH_EN is defined.
module hyperram_line_cache #(
  parameter int unsigned ADDR_W = 22,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned WORDS  = 8,
  parameter int unsigned LINES  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s0_address,
  input  logic              s0_read,
  input  logic              s0_write,
  input  logic [DATA_W-1:0] s0_writedata,
  output logic [DATA_W-1:0] s0_readdata,
  output logic              s0_readdatavalid,
  output logic              s0_waitrequest,
  output logic              mem_cmd_valid,
  input  logic              mem_cmd_ready,
  output logic              mem_cmd_write,
  output logic [ADDR_W-1:0] mem_cmd_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wdata_valid,
  input  logic              mem_wdata_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdata_valid,
  input  logic              mem_done,
  input  logic              flush,
  output logic              flush_busy,
  output logic              err
);
  localparam int unsigned OFS_W    = $clog2(WORDS);
  localparam int unsigned IDX_W    = $clog2(LINES);
  localparam int unsigned TAG_W    = ADDR_W - OFS_W - IDX_W;
  localparam int unsigned CNT_W    = OFS_W + 1;
  localparam int unsigned LAST_IDX = LINES - 1;

  typedef enum logic [2:0] {
    IDLE, EVICT_CMD, EVICT_DATA, EVICT_WAIT, FILL_CMD, FILL_DATA, FLUSH_SCAN
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] line_q [LINES*WORDS];
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINES-1:0]  valid_q, dirty_q;
  logic [IDX_W-1:0]  idx_q;
  logic [TAG_W-1:0]  req_tag_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              flushing_q;
  logic              err_q;

  logic [OFS_W-1:0] a_ofs;
  logic [IDX_W-1:0] a_idx;
  logic [TAG_W-1:0] a_tag;
  logic             req_c, hit_c, flush_c;
  logic             rd_hit, wr_hit, miss, flush_go, scan_inc, scan_end;
  logic             cnt_clr, cnt_inc, evict_done, fill_start, fill_we, fill_ok, fill_bad;

  assign a_ofs = s0_address[OFS_W-1:0];
  assign a_idx = s0_address[OFS_W +: IDX_W];
  assign a_tag = s0_address[ADDR_W-1 -: TAG_W];
  assign req_c = s0_read | s0_write;
  assign hit_c = valid_q[a_idx] && (tag_q[a_idx] == a_tag);

`ifdef HYPERRAM_CACHE_FLUSH_EN
  assign flush_c = flush;
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign flush_c      = 1'b0;
`endif

  assign s0_waitrequest = (state != IDLE) | flush_c | (req_c & ~hit_c);
  assign flush_busy     = flushing_q;
  assign err            = err_q;

  // Next state and datapath strobes
  always_comb begin
    state_nxt  = state;
    rd_hit     = 1'b0;
    wr_hit     = 1'b0;
    miss       = 1'b0;
    flush_go   = 1'b0;
    scan_inc   = 1'b0;
    scan_end   = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    evict_done = 1'b0;
    fill_start = 1'b0;
    fill_we    = 1'b0;
    fill_ok    = 1'b0;
    fill_bad   = 1'b0;
    case (state)
      IDLE: begin
        if (flush_c) begin
          flush_go  = 1'b1;
          state_nxt = FLUSH_SCAN;
        end else if (req_c && hit_c) begin
          rd_hit = s0_read;
          wr_hit = s0_write;
        end else if (req_c) begin
          miss      = 1'b1;
          state_nxt = (valid_q[a_idx] && dirty_q[a_idx]) ? EVICT_CMD : FILL_CMD;
        end
      end
      EVICT_CMD: begin
        if (mem_cmd_ready) begin
          cnt_clr   = 1'b1;
          state_nxt = EVICT_DATA;
        end
      end
      EVICT_DATA: begin
        if (mem_wdata_ready) begin
          cnt_inc = 1'b1;
          if (cnt_q == CNT_W'(WORDS - 1)) state_nxt = EVICT_WAIT;
        end
      end
      EVICT_WAIT: begin
        if (mem_done) begin
          evict_done = 1'b1;
          state_nxt  = flushing_q ? FLUSH_SCAN : FILL_CMD;
        end
      end
      FILL_CMD: begin
        if (mem_cmd_ready) begin
          cnt_clr    = 1'b1;
          fill_start = 1'b1;
          state_nxt  = FILL_DATA;
        end
      end
      FILL_DATA: begin
        // Beats past a full line are dropped
        fill_we = mem_rdata_valid && (cnt_q < CNT_W'(WORDS));
        cnt_inc = fill_we;
        if (mem_done) begin
          state_nxt = IDLE;
          if ((cnt_q == CNT_W'(WORDS)) || (fill_we && (cnt_q == CNT_W'(WORDS - 1))))
            fill_ok = 1'b1;
          else
            fill_bad = 1'b1;
        end
      end
`ifdef HYPERRAM_CACHE_FLUSH_EN
      FLUSH_SCAN: begin
        if (valid_q[idx_q] && dirty_q[idx_q]) begin
          state_nxt = EVICT_CMD;
        end else if (idx_q == IDX_W'(LAST_IDX)) begin
          scan_end  = 1'b1;
          state_nxt = IDLE;
        end else begin
          scan_inc = 1'b1;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Memory-side command and write-data outputs decoded from state
  always_comb begin
    mem_cmd_valid   = 1'b0;
    mem_cmd_write   = 1'b0;
    mem_cmd_addr    = '0;
    mem_wdata_valid = 1'b0;
    mem_wdata       = line_q[{idx_q, cnt_q[OFS_W-1:0]}];
    if (state == EVICT_CMD) begin
      mem_cmd_valid = 1'b1;
      mem_cmd_write = 1'b1;
      mem_cmd_addr  = {tag_q[idx_q], idx_q, {OFS_W{1'b0}}};
    end else if (state == FILL_CMD) begin
      mem_cmd_valid = 1'b1;
      mem_cmd_addr  = {req_tag_q, idx_q, {OFS_W{1'b0}}};
    end
    if (state == EVICT_DATA) mem_wdata_valid = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Line state, counters and s0 read response
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q          <= '0;
      dirty_q          <= '0;
      err_q            <= 1'b0;
      cnt_q            <= '0;
      idx_q            <= '0;
      req_tag_q        <= '0;
      flushing_q       <= 1'b0;
      s0_readdata      <= '0;
      s0_readdatavalid <= 1'b0;
    end else begin
      s0_readdatavalid <= rd_hit;
      if (rd_hit) s0_readdata <= line_q[{a_idx, a_ofs}];
      if (wr_hit) dirty_q[a_idx] <= 1'b1;
      if (miss) begin
        idx_q     <= a_idx;
        req_tag_q <= a_tag;
      end
      if (flush_go) begin
        idx_q      <= '0;
        flushing_q <= 1'b1;
      end
      if (scan_inc) idx_q <= idx_q + IDX_W'(1);
      if (scan_end) flushing_q <= 1'b0;
      if (cnt_clr)      cnt_q <= '0;
      else if (cnt_inc) cnt_q <= cnt_q + CNT_W'(1);
      if (evict_done) dirty_q[idx_q] <= 1'b0;
      if (fill_start) valid_q[idx_q] <= 1'b0;
      if (fill_ok) begin
        valid_q[idx_q] <= 1'b1;
        dirty_q[idx_q] <= 1'b0;
      end
      if (fill_bad) err_q <= 1'b1;
    end
  end

  // Line data and tags carry no reset; valid_q guards them
  always_ff @(posedge clk) begin
    if (wr_hit)  line_q[{a_idx, a_ofs}] <= s0_writedata;
    if (fill_we) line_q[{idx_q, cnt_q[OFS_W-1:0]}] <= mem_rdata;
    if (fill_ok) tag_q[idx_q] <= req_tag_q;
  end
endmodule
